// File: rtl/bcd_pkg.sv
// bcd_pkg: digit-path types and constants shared by the accumulator and the separator
package bcd_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;
endpackage

// File: rtl/bcd_digit_accumulator_mul10_add.sv
// mul10_add: y = x*10 + d, saturating to all-ones with ovf when the result exceeds WIDTH bits
module mul10_add
  import bcd_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0]   i_x,
  input  logic [DIGIT_W-1:0] i_d,
  output logic [WIDTH-1:0]   o_y,
  output logic               o_ovf
);
  logic [WIDTH+3:0] w_ext;
  logic [WIDTH+3:0] w_full;
  // Four guard bits hold the worst case (2**WIDTH-1)*10+15
  always_comb begin
    w_ext  = {4'b0, i_x};
    w_full = (w_ext << 3) + (w_ext << 1) + {{WIDTH{1'b0}}, i_d};
    o_ovf  = |w_full[WIDTH+3:WIDTH];
    o_y    = o_ovf ? {WIDTH{1'b1}} : w_full[WIDTH-1:0];
  end
endmodule

// File: rtl/bcd_digit_accumulator.sv
// bcd_digit_accumulator: assembles MSB-first BCD digits into a binary value with valid/ready commit
module bcd_digit_accumulator
  import bcd_pkg::*;
#(
  parameter int WIDTH      = 9,
  parameter int MAX_DIGITS = 3,
  parameter int CW         = $clog2(MAX_DIGITS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit,
  output logic               digit_ready,
  input  logic               enter,
  input  logic               clear,
  output logic [WIDTH-1:0]   value_out,
  output logic               value_valid,
  input  logic               value_ready,
  output logic               overflow,
  output logic               bad_digit,
  output logic [CW-1:0]      digit_count
);
  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_value;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             r_bad;
  logic [WIDTH-1:0] w_next;
  logic             w_next_ovf;

  mul10_add #(.WIDTH(WIDTH)) u_mul10_add (
    .i_x   (r_acc),
    .i_d   (digit),
    .o_y   (w_next),
    .o_ovf (w_next_ovf)
  );

  assign digit_ready = (r_state != S_HOLD) && !enter && !clear;
  assign value_valid = r_state == S_HOLD;
  assign value_out   = r_value;
  assign overflow    = r_ovf;
  assign bad_digit   = r_bad;
  assign digit_count = r_count;

  // Entry FSM: clear beats the hold handshake, which beats enter, which beats a digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_value <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_bad   <= 1'b0;
    end else begin
      r_bad <= 1'b0;
      if (clear || (r_state == S_HOLD && value_ready)) begin
        r_state <= S_IDLE;
        r_acc   <= '0;
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (r_state == S_HOLD) begin
        r_state <= S_HOLD;
      end else if (enter) begin
        if (r_state == S_ACCUM) begin
          r_value <= r_acc;
          r_state <= S_HOLD;
        end
      end else if (digit_valid) begin
        if (digit > BCD_MAX) begin
          r_bad <= 1'b1;
        end else if (r_count == CW'(MAX_DIGITS)) begin
          r_ovf <= 1'b1;
        end else begin
          r_acc   <= w_next;
          r_ovf   <= r_ovf | w_next_ovf;
          r_count <= r_count + 1'b1;
          r_state <= S_ACCUM;
        end
      end
    end
  end
endmodule

// File: tb/tb_bcd_digit_accumulator.sv
// tb_bcd_digit_accumulator: directed self-checking bench for the BCD digit accumulator
module tb_bcd_digit_accumulator;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       digit_valid;
  logic [3:0] digit;
  logic       digit_ready;
  logic       enter;
  logic       clear;
  logic [8:0] value_out;
  logic       value_valid;
  logic       value_ready;
  logic       overflow;
  logic       bad_digit;
  logic [1:0] digit_count;
  int checks = 0;
  int errors = 0;

  bcd_digit_accumulator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digit_valid (digit_valid),
    .digit       (digit),
    .digit_ready (digit_ready),
    .enter       (enter),
    .clear       (clear),
    .value_out   (value_out),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .overflow    (overflow),
    .bad_digit   (bad_digit),
    .digit_count (digit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [3:0] d);
    digit_valid = 1'b1;
    digit = d;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic commit();
    enter = 1'b1;
    tick();
    enter = 1'b0;
  endtask

  task automatic ack();
    value_ready = 1'b1;
    tick();
    value_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; digit_valid = 1'b0; digit = 4'd0; enter = 1'b0; clear = 1'b0; value_ready = 1'b0;
    #3;
    chk("rst_value", value_out, 0);
    chk("rst_valid", value_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_bad", bad_digit, 0);
    chk("rst_count", digit_count, 0);
    chk("rst_ready", digit_ready, 1);
    tick();
    rst_n = 1'b1;
    // 1: 1,2,3 -> 123
    put(4'd1);
    chk("t1_count1", digit_count, 1);
    put(4'd2);
    put(4'd3);
    chk("t1_count3", digit_count, 3);
    chk("t1_novalid", value_valid, 0);
    commit();
    chk("t1_valid", value_valid, 1);
    chk("t1_value", value_out, 123);
    chk("t1_ovf", overflow, 0);
    chk("t1_count_hold", digit_count, 3);
    ack();
    chk("t1_ack_valid", value_valid, 0);
    chk("t1_ack_count", digit_count, 0);
    // 2: 5,1,2 saturates; 4,0,0 then dropped 7
    put(4'd5);
    put(4'd1);
    chk("t2_ovf_before", overflow, 0);
    put(4'd2);
    chk("t2_ovf_sat", overflow, 1);
    commit();
    chk("t2_value_sat", value_out, 511);
    chk("t2_ovf_hold", overflow, 1);
    ack();
    chk("t2_ovf_cleared", overflow, 0);
    put(4'd4);
    put(4'd0);
    put(4'd0);
    chk("t2_ovf_400", overflow, 0);
    put(4'd7);
    chk("t2_drop_ovf", overflow, 1);
    chk("t2_drop_count", digit_count, 3);
    commit();
    chk("t2_value_400", value_out, 400);
    chk("t2_ovf_400_hold", overflow, 1);
    ack();
    // 3: 4,C,2 -> 42 with a one-cycle bad_digit
    put(4'd4);
    chk("t3_bad_idle", bad_digit, 0);
    put(4'hC);
    chk("t3_bad_pulse", bad_digit, 1);
    chk("t3_bad_count", digit_count, 1);
    put(4'd2);
    chk("t3_bad_end", bad_digit, 0);
    chk("t3_count2", digit_count, 2);
    commit();
    chk("t3_value", value_out, 42);
    ack();
    // 4: hold with value_ready low for 5 cycles while a digit is offered
    put(4'd9);
    commit();
    digit_valid = 1'b1;
    digit = 4'd3;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", value_valid, 1);
      chk("t4_hold_value", value_out, 9);
      chk("t4_hold_ready", digit_ready, 0);
      tick();
    end
    chk("t4_hold_count", digit_count, 1);
    digit_valid = 1'b0;
    ack();
    chk("t4_release_valid", value_valid, 0);
    chk("t4_release_ready", digit_ready, 1);
    // 5: clear + enter + digit in one cycle
    put(4'd8);
    clear = 1'b1; enter = 1'b1; digit_valid = 1'b1; digit = 4'd5;
    #1;
    chk("t5_ready_low", digit_ready, 0);
    tick();
    clear = 1'b0; enter = 1'b0; digit_valid = 1'b0;
    chk("t5_valid", value_valid, 0);
    chk("t5_count", digit_count, 0);
    chk("t5_value_kept", value_out, 9);
    put(4'd6);
    commit();
    chk("t5_acc_zeroed", value_out, 6);
    ack();
    // 6: async reset mid-entry and in hold
    put(4'd1);
    put(4'd2);
    chk("t6_count2", digit_count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_count", digit_count, 0);
    chk("t6_rst_value", value_out, 0);
    tick();
    rst_n = 1'b1;
    put(4'd3);
    commit();
    chk("t6_hold_valid", value_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_hold_valid", value_valid, 0);
    chk("t6_rst_hold_value", value_out, 0);
    chk("t6_rst_hold_count", digit_count, 0);
    tick();
    rst_n = 1'b1;
    put(4'd7);
    commit();
    chk("t6_after_reset", value_out, 7);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
